// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and types for the parametrised synchronous FIFO.
//   DEFAULT_DATA_WIDTH / DEFAULT_INDEX_WIDTH : default entry width and log2(depth)
//   DEFAULT_AF_THRESH / DEFAULT_AE_THRESH    : default almost-full / almost-empty margins
//   fifo_flags_t                             : status flag bundle driven by the top
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_INDEX_WIDTH = 5;
  localparam int DEFAULT_AF_THRESH   = 2;
  localparam int DEFAULT_AE_THRESH   = 1;

  typedef struct packed {
    logic overflow;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: read/write pointers, occupancy count and full/empty for sync_fifo_param.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   wr_req       : producer offers a word (in_valid)
//   rd_req       : consumer accepts head (out_ready)
//   push, pop    : completed handshakes this cycle
//   wr_addr      : storage index for the write
//   rd_addr      : storage index of the head entry
//   count        : entries stored, 0..DEPTH
//   full, empty  : pointer-derived occupancy state
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_req,
  input  logic                   rd_req,
  output logic                   push,
  output logic                   pop,
  output logic [INDEX_WIDTH-1:0] wr_addr,
  output logic [INDEX_WIDTH-1:0] rd_addr,
  output logic [INDEX_WIDTH:0]   count,
  output logic                   full,
  output logic                   empty
);

  // One extra pointer bit distinguishes full from empty when the low bits match.
  logic [INDEX_WIDTH:0] wr_ptr, rd_ptr;

  assign full  = (wr_ptr[INDEX_WIDTH] != rd_ptr[INDEX_WIDTH]) &&
                 (wr_ptr[INDEX_WIDTH-1:0] == rd_ptr[INDEX_WIDTH-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Full blocks writes even when a pop happens the same cycle (no pass-through).
  // Nothing completes on a reset cycle.
  assign push = wr_req && !full  && !rst;
  assign pop  = rd_req && !empty && !rst;

  assign wr_addr = wr_ptr[INDEX_WIDTH-1:0];
  assign rd_addr = rd_ptr[INDEX_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised synchronous FIFO, first-word fall-through, valid/ready on
// both sides, programmable almost-full/almost-empty, live count and sticky overflow.
// Optional feature: define FIFO_HIGH_WATER_EN to add the high_water output (max count since
// reset or last clr_flags).
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   in_data/in_valid/in_ready     : write side handshake (in_ready = !full)
//   out_data/out_valid/out_ready  : read side handshake (out_valid = !empty)
//   count                  : entries stored, 0..DEPTH
//   almost_full            : count >= DEPTH-AF_THRESH
//   almost_empty           : count <= AE_THRESH
//   overflow               : sticky, set when a write is offered while full
//   clr_flags              : clears overflow (and reloads high_water)
//   high_water             : (FIFO_HIGH_WATER_EN only) peak count
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int AF_THRESH   = DEFAULT_AF_THRESH,
  parameter int AE_THRESH   = DEFAULT_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INDEX_WIDTH:0]  count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
`ifdef FIFO_HIGH_WATER_EN
  output logic [INDEX_WIDTH:0]  high_water,
`endif
  input  logic                  clr_flags
);

  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam logic [INDEX_WIDTH:0] AF_LEVEL =
    (AF_THRESH >= DEPTH) ? '0 : (INDEX_WIDTH+1)'(DEPTH - AF_THRESH);
  localparam logic [INDEX_WIDTH:0] AE_LEVEL = (INDEX_WIDTH+1)'(AE_THRESH);

  logic                   push, pop, full, empty;
  logic [INDEX_WIDTH-1:0] wr_addr, rd_addr;
  logic                   ovf_q;
  fifo_flags_t            flags;

  fifo_ptr_ctrl #(.INDEX_WIDTH(INDEX_WIDTH)) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .wr_req (in_valid),
    .rd_req (out_ready),
    .push   (push),
    .pop    (pop),
    .wr_addr(wr_addr),
    .rd_addr(rd_addr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Storage is intentionally not reset; pointers define validity.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push) mem[wr_addr] <= in_data;
  end

  assign out_data  = mem[rd_addr];
  assign in_ready  = !full;
  assign out_valid = !empty;

  // Set wins over clear when both happen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)                   ovf_q <= 1'b0;
    else if (in_valid && full) ovf_q <= 1'b1;
    else if (clr_flags)        ovf_q <= 1'b0;
  end

  always_comb begin
    flags.overflow     = ovf_q;
    flags.almost_full  = (AF_THRESH >= DEPTH) ? 1'b1 : (count >= AF_LEVEL);
    flags.almost_empty = (count <= AE_LEVEL);
  end

  assign overflow     = flags.overflow;
  assign almost_full  = flags.almost_full;
  assign almost_empty = flags.almost_empty;

`ifdef FIFO_HIGH_WATER_EN
  // Tracks the registered count, so the peak appears one cycle after count rises.
  logic [INDEX_WIDTH:0] hw_q;

  always_ff @(posedge clk) begin
    if (rst)                hw_q <= '0;
    else if (clr_flags)     hw_q <= count;
    else if (count > hw_q)  hw_q <= count;
  end

  assign high_water = hw_q;
`endif

endmodule
